// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions.
// Holds the opcodes used by the ID, EX and MEM stages, the iterative engine's
// FSM encoding and its iteration count.
package mips32_pkg;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpSlt   = 6'b000100;
  localparam logic [5:0] OpMul   = 6'b000101;
  localparam logic [5:0] OpDiv   = 6'b000110;
  localparam logic [5:0] OpLw    = 6'b001000;
  localparam logic [5:0] OpSw    = 6'b001001;
  localparam logic [5:0] OpAddi  = 6'b001010;
  localparam logic [5:0] OpSubi  = 6'b001011;
  localparam logic [5:0] OpSlti  = 6'b001100;
  localparam logic [5:0] OpBneqz = 6'b001101;
  localparam logic [5:0] OpBeqz  = 6'b001110;
  localparam logic [5:0] OpHlt   = 6'b111111;

  typedef enum logic [0:0] {StIdle, StRun} md_state_e;

  localparam int unsigned    MdIters    = 32;
  localparam int unsigned    MdCntW     = 5;
  localparam logic [MdCntW-1:0] MdLastIter = MdCntW'(MdIters - 1);

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply / divide engine for the EX stage.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         load operands and begin (ignored while running)
//   op            0 = MUL (low word of signed product), 1 = DIV (signed quotient)
//   a, b          operands sampled on start
//   done          high during the final iteration; result is valid with it
//   result        final value, combinational alongside done
// Divider datapath is present only when EX_ITER_DIV_EN is defined.
module ex_muldiv
  import mips32_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  md_state_e         state_q, state_d;
  logic [MdCntW-1:0] cnt_q, cnt_d;
  // acc: product accumulator or partial remainder.
  // x:   multiplier (shifts right) or dividend becoming quotient (shifts left).
  // y:   multiplicand (shifts left) or divisor magnitude.
  logic [DATA_W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] acc_step, x_step, y_step;

`ifdef EX_ITER_DIV_EN
  logic              op_q, op_d;
  logic              neg_q, neg_d;
  logic [DATA_W:0]   rem_sh, rem_diff;
`else
  logic              unused_op;
  assign unused_op = op;
`endif

  // One iteration of the selected algorithm plus the final-result mapping.
  always_comb begin
    acc_step = acc_q + (x_q[0] ? y_q : '0);
    x_step   = x_q >> 1;
    y_step   = y_q << 1;
    result   = acc_step;
`ifdef EX_ITER_DIV_EN
    rem_sh   = {acc_q, x_q[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, y_q};
    if (op_q) begin
      y_step = y_q;
      if (!rem_diff[DATA_W]) begin
        acc_step = rem_diff[DATA_W-1:0];
        x_step   = {x_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = rem_sh[DATA_W-1:0];
        x_step   = {x_q[DATA_W-2:0], 1'b0};
      end
      // Magnitude quotient of 0x80000000 / 1 negates back to 0x80000000.
      result = neg_q ? -x_step : x_step;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    done    = 1'b0;
`ifdef EX_ITER_DIV_EN
    op_d    = op_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          acc_d   = '0;
          x_d     = b;
          y_d     = a;
`ifdef EX_ITER_DIV_EN
          op_d    = op;
          neg_d   = a[DATA_W-1] ^ b[DATA_W-1];
          if (op) begin
            x_d = a[DATA_W-1] ? -a : a;
            y_d = b[DATA_W-1] ? -b : b;
          end
`endif
        end
      end
      StRun: begin
        acc_d = acc_step;
        x_d   = x_step;
        y_d   = y_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MdLastIter) begin
          done    = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
`ifdef EX_ITER_DIV_EN
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef EX_ITER_DIV_EN
      op_q    <= op_d;
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU plus the EX/MEM pipeline register.
// MUL (and DIV when EX_ITER_DIV_EN is defined) run on ex_muldiv for 32
// cycles while busy stalls upstream.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid                       ID/EX holds a real instruction
//   npc_in, a_in, b_in, imm_in     ID/EX operands
//   ir_in                          instruction word, opcode in [31:26]
//   busy                           iterative op in flight (registered)
//   out_valid                      EX/MEM holds a new instruction this cycle
//   alu_out, b_out, ir_out         EX/MEM result, store data, instruction
//   cond_out                       a_in == 0 for the accepted op
//   halted                         sticky, set by HLT until rst
// Macro EX_ITER_DIV_EN: enables the iterative divider; otherwise DIV yields 0.
module ex_stage
  import mips32_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] ir_in,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              cond_out,
  output logic              halted
);

  logic [5:0]        opcode;
  logic              accept;
  logic [DATA_W-1:0] alu_res;
  logic              iter_op;
  logic              md_op;
  logic              md_done;
  logic [DATA_W-1:0] md_result;

  assign opcode = ir_in[31:26];
  assign accept = in_valid & ~busy & ~halted;

  always_comb begin
    alu_res = '0;
    iter_op = 1'b0;
    md_op   = 1'b0;
    case (opcode)
      OpAdd:   alu_res = a_in + b_in;
      OpSub:   alu_res = a_in - b_in;
      OpAnd:   alu_res = a_in & b_in;
      OpOr:    alu_res = a_in | b_in;
      OpSlt:   alu_res = {{(DATA_W-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OpMul:   iter_op = 1'b1;
      OpDiv: begin
`ifdef EX_ITER_DIV_EN
        // Divide by zero completes immediately with all ones.
        if (b_in == '0) begin
          alu_res = '1;
        end else begin
          iter_op = 1'b1;
          md_op   = 1'b1;
        end
`else
        alu_res = '0;
`endif
      end
      OpLw, OpSw, OpAddi: alu_res = a_in + imm_in;
      OpSubi:  alu_res = a_in - imm_in;
      OpSlti:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a_in) < $signed(imm_in)};
      OpBneqz, OpBeqz: alu_res = npc_in + imm_in;
      default: alu_res = '0;  // HLT and unknown opcodes
    endcase
  end

  ex_muldiv #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept & iter_op),
    .op     (md_op),
    .a      (a_in),
    .b      (b_in),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      b_out     <= '0;
      ir_out    <= '0;
      cond_out  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (md_done) begin
        alu_out   <= md_result;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else if (accept) begin
        b_out    <= b_in;
        ir_out   <= ir_in;
        cond_out <= (a_in == '0);
        if (iter_op) begin
          busy <= 1'b1;
        end else begin
          alu_out   <= alu_res;
          out_valid <= 1'b1;
        end
        if (opcode == OpHlt) halted <= 1'b1;
      end
    end
  end

endmodule
